serial_deserializer: RTL

Serial-in, parallel-out receiver. It collects a bit stream produced by the team's universal shift register, or by any serial source, into WIDTH-bit words. The bit order is selectable per frame, MSB-first or LSB-first. Completed words go to a holding register with a valid/ready handshake, so reception of the next frame overlaps output consumption. It sits at the receive end of the serial links between datapath blocks.

---
 rtl/serial_deserializer_pkg.sv | 18 +
 rtl/serial_deserializer_if.sv | 32 +++
 rtl/deser_hold_reg.sv | 50 +++++
 rtl/serial_deserializer.sv | 126 ++++++++++++
 4 files changed

// File: rtl/serial_deserializer_pkg.sv
// Shared definitions for the serial deserializer: state encoding, bit-order
// constants and the bit-counter width derivation.
package serial_deserializer_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // Same encoding the universal shift register's S0/S1 users rely on.
    localparam logic DIR_LSB = 1'b0;
    localparam logic DIR_MSB = 1'b1;

    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/serial_deserializer_if.sv
// Serial input, parallel output and status bundle of the deserializer.
interface serial_deserializer_if #(
    parameter int WIDTH = 8
);
    import serial_deserializer_pkg::*;

    localparam int CNT_W = cnt_w(WIDTH);

    logic             Sin;
    logic             Sin_valid;
    logic             Start;
    logic             Msb_first;
    logic             Err_clr;
    logic [WIDTH-1:0] Pout;
    logic             Pout_valid;
    logic             Pout_ready;
    logic             Busy;
    logic [CNT_W-1:0] Bit_count;
    logic             Overrun;
    logic             Frame_err;

    modport master (
        output Sin, Sin_valid, Start, Msb_first, Err_clr, Pout_ready,
        input  Pout, Pout_valid, Busy, Bit_count, Overrun, Frame_err
    );

    modport slave (
        input  Sin, Sin_valid, Start, Msb_first, Err_clr, Pout_ready,
        output Pout, Pout_valid, Busy, Bit_count, Overrun, Frame_err
    );

endinterface

// File: rtl/deser_hold_reg.sv
// Single-entry holding register with valid/ready; a word arriving while the
// held word is still unconsumed is dropped and flagged.
module deser_hold_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             ready,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    output logic             drop
);

    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;

    // A consume on the same edge frees the slot for the incoming word.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        drop    = 1'b0;
        if (valid_q && ready) begin
            valid_d = 1'b0;
        end
        if (load) begin
            if (!valid_q || ready) begin
                data_d  = load_data;
                valid_d = 1'b1;
            end else begin
                drop = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign data  = data_q;
    assign valid = valid_q;

endmodule

// File: rtl/serial_deserializer.sv
// Serial-in, parallel-out receiver with per-frame bit order, a valid/ready
// output holding register and sticky overrun / frame-restart flags.
module serial_deserializer
    import serial_deserializer_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CNT_W = cnt_w(WIDTH)
) (
    input  logic                 Clk,
    input  logic                 Clear,
    serial_deserializer_if.slave bus
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic             overrun_q, overrun_d;
    logic             frame_err_q, frame_err_d;
    logic             complete;
    logic             restart;
    logic             drop;
    logic [WIDTH-1:0] pout;
    logic             pout_valid;

    function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] sh,
                                                  input logic bit_in,
                                                  input logic dir);
        return (dir == DIR_MSB) ? {sh[WIDTH-2:0], bit_in} : {bit_in, sh[WIDTH-1:1]};
    endfunction

    always_comb begin
        state_d  = state_q;
        sh_d     = sh_q;
        cnt_d    = cnt_q;
        dir_d    = dir_q;
        complete = 1'b0;
        restart  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.Sin_valid && bus.Start) begin
                    sh_d    = shift_in('0, bus.Sin, bus.Msb_first);
                    dir_d   = bus.Msb_first;
                    cnt_d   = CNT_W'(1);
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (bus.Sin_valid) begin
                    if (bus.Start) begin
                        // Restart: the fresh shift discards the partial word.
                        restart = 1'b1;
                        sh_d    = shift_in('0, bus.Sin, bus.Msb_first);
                        dir_d   = bus.Msb_first;
                        cnt_d   = CNT_W'(1);
                    end else begin
                        sh_d = shift_in(sh_q, bus.Sin, dir_q);
                        if (cnt_q == CNT_W'(WIDTH - 1)) begin
                            complete = 1'b1;
                            cnt_d    = '0;
                            state_d  = ST_IDLE;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Set events take priority over a same-cycle clear request.
    always_comb begin
        overrun_d   = overrun_q;
        frame_err_d = frame_err_q;
        if (bus.Err_clr) begin
            overrun_d   = 1'b0;
            frame_err_d = 1'b0;
        end
        if (drop) begin
            overrun_d = 1'b1;
        end
        if (restart) begin
            frame_err_d = 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Clear) begin
        if (!Clear) begin
            state_q     <= ST_IDLE;
            sh_q        <= '0;
            cnt_q       <= '0;
            dir_q       <= DIR_LSB;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sh_q        <= sh_d;
            cnt_q       <= cnt_d;
            dir_q       <= dir_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

    deser_hold_reg #(
        .WIDTH (WIDTH)
    ) u_hold (
        .clk       (Clk),
        .rst_n     (Clear),
        .load      (complete),
        .load_data (sh_d),
        .ready     (bus.Pout_ready),
        .data      (pout),
        .valid     (pout_valid),
        .drop      (drop)
    );

    assign bus.Pout       = pout;
    assign bus.Pout_valid = pout_valid;
    assign bus.Busy       = (state_q == ST_SHIFT);
    assign bus.Bit_count  = cnt_q;
    assign bus.Overrun    = overrun_q;
    assign bus.Frame_err  = frame_err_q;

endmodule
